// File: rtl/approx_mon_pkg.sv
// Shared types, default widths and saturating-add helpers for the approximate-adder error monitor.
package approx_mon_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned CNT_W_DEF = 32;
   localparam int unsigned ACC_W_DEF = 48;
   // Working width of the saturating helpers; callers extend into it and cast back.
   localparam int unsigned SAT_W     = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mon_state_e;

   function automatic logic [SAT_W-1:0] sat_add_u(
      input  logic [SAT_W-1:0] a,
      input  logic [SAT_W-1:0] b,
      input  int unsigned      w,
      output logic             ovf
   );
      logic [SAT_W:0] sum;
      logic [SAT_W:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
      if (sum > lim) begin
         ovf       = 1'b1;
         sat_add_u = lim[SAT_W-1:0];
      end else begin
         ovf       = 1'b0;
         sat_add_u = sum[SAT_W-1:0];
      end
   endfunction

   // Two's-complement add clamped to the signed range of a w-bit value.
   function automatic logic [SAT_W-1:0] sat_add_s(
      input logic [SAT_W-1:0] a,
      input logic [SAT_W-1:0] b,
      input int unsigned      w
   );
      logic signed [SAT_W:0] sum;
      logic signed [SAT_W:0] hi;
      logic signed [SAT_W:0] lo;
      sum = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
      hi  = $signed(({{SAT_W{1'b0}}, 1'b1} << (w - 32'd1)) - {{SAT_W{1'b0}}, 1'b1});
      lo  = -hi - $signed({{SAT_W{1'b0}}, 1'b1});
      if (sum > hi) begin
         sat_add_s = hi[SAT_W-1:0];
      end else if (sum < lo) begin
         sat_add_s = lo[SAT_W-1:0];
      end else begin
         sat_add_s = sum[SAT_W-1:0];
      end
   endfunction

endpackage

// File: rtl/approx_ed_stage.sv
// First pipeline stage: exact sum and registered error distance of the approximate result.
// Build option APPROX_MON_BIAS_EN additionally registers the signed error exact - approx.
module approx_ed_stage
   import approx_mon_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               valid_i,
   input  logic [WIDTH-1:0]   add1_i,
   input  logic [WIDTH-1:0]   add2_i,
   input  logic [WIDTH:0]     approx_i,
   output logic               valid_o,
   output logic [WIDTH:0]     ed_o
`ifdef APPROX_MON_BIAS_EN
   ,
   output logic signed [WIDTH+1:0] diff_o
`endif
);

   logic [WIDTH:0] exact_s;
   logic [WIDTH:0] ed_s;
`ifdef APPROX_MON_BIAS_EN
   logic signed [WIDTH+1:0] diff_s;
`endif

   // Exact sum and unsigned magnitude of its distance from the DUT result.
   always_comb begin
      exact_s = {1'b0, add1_i} + {1'b0, add2_i};
      if (exact_s >= approx_i) begin
         ed_s = exact_s - approx_i;
      end else begin
         ed_s = approx_i - exact_s;
      end
`ifdef APPROX_MON_BIAS_EN
      diff_s = $signed({1'b0, exact_s}) - $signed({1'b0, approx_i});
`endif
   end

   // Stage register; a flush drops whatever sample is entering the pipe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         ed_o    <= {(WIDTH+1){1'b0}};
`ifdef APPROX_MON_BIAS_EN
         diff_o  <= {(WIDTH+2){1'b0}};
`endif
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            ed_o   <= ed_s;
`ifdef APPROX_MON_BIAS_EN
            diff_o <= diff_s;
`endif
         end
      end
   end

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Windowed accuracy monitor for approximate adders: error count, saturating ED sum and max ED.
// Define APPROX_MON_BIAS_EN to add bias_o, the saturating signed sum of exact - approx.
module approx_adder_error_monitor
   import approx_mon_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned ACC_W = ACC_W_DEF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [CNT_W-1:0]   num_samples_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [WIDTH-1:0]   add1_i,
   input  logic [WIDTH-1:0]   add2_i,
   input  logic [WIDTH:0]     approx_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [CNT_W-1:0]   sample_cnt_o,
   output logic [CNT_W-1:0]   err_cnt_o,
   output logic [ACC_W-1:0]   sum_ed_o,
   output logic [WIDTH:0]     max_ed_o,
   output logic               sat_o
`ifdef APPROX_MON_BIAS_EN
   ,
   output logic signed [ACC_W-1:0] bias_o
`endif
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   mon_state_e       state_r;
   logic [CNT_W-1:0] limit_r;
   logic [CNT_W-1:0] acc_cnt_r;
   logic             handshake_s;
   logic             s1_vld_s;
   logic [WIDTH:0]   ed_s;
   logic [ACC_W-1:0] sum_ed_nxt_s;
   logic             sum_ovf_s;
   logic [WIDTH:0]   max_ed_nxt_s;
   logic [CNT_W-1:0] err_inc_s;
`ifdef APPROX_MON_BIAS_EN
   logic signed [WIDTH+1:0] diff_s;
   logic signed [ACC_W-1:0] bias_nxt_s;
`endif

   assign handshake_s = valid_i & ready_o;

   approx_ed_stage #(
      .WIDTH (WIDTH)
   ) u_ed_stage (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .flush_i  (start_i),
      .valid_i  (handshake_s),
      .add1_i   (add1_i),
      .add2_i   (add2_i),
      .approx_i (approx_i),
      .valid_o  (s1_vld_s),
      .ed_o     (ed_s)
`ifdef APPROX_MON_BIAS_EN
      ,
      .diff_o   (diff_s)
`endif
   );

   // Window control; start_i from any state clears and re-arms.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r   <= IDLE;
         limit_r   <= CNT_ZERO;
         acc_cnt_r <= CNT_ZERO;
         ready_o   <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else if (start_i) begin
         limit_r   <= num_samples_i;
         acc_cnt_r <= CNT_ZERO;
         if (num_samples_i == CNT_ZERO) begin
            state_r <= DONE;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
         end else begin
            state_r <= RUN;
            ready_o <= 1'b1;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               state_r <= IDLE;
            end
            RUN: begin
               if (handshake_s) begin
                  acc_cnt_r <= acc_cnt_r + CNT_ONE;
                  if ((acc_cnt_r + CNT_ONE) == limit_r) begin
                     state_r <= DRAIN;
                     ready_o <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (!s1_vld_s) begin
                  state_r <= DONE;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
               end
            end
            DONE: begin
               state_r <= DONE;
            end
            default: begin
               state_r <= IDLE;
               ready_o <= 1'b0;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
            end
         endcase
      end
   end

   // Next statistic values for the sample leaving the first stage.
   always_comb begin
      sum_ovf_s    = 1'b0;
      sum_ed_nxt_s = ACC_W'(sat_add_u({{(SAT_W-ACC_W){1'b0}}, sum_ed_o},
                                      {{(SAT_W-WIDTH-1){1'b0}}, ed_s},
                                      ACC_W, sum_ovf_s));
      if (ed_s > max_ed_o) begin
         max_ed_nxt_s = ed_s;
      end else begin
         max_ed_nxt_s = max_ed_o;
      end
      if (ed_s != {(WIDTH+1){1'b0}}) begin
         err_inc_s = CNT_ONE;
      end else begin
         err_inc_s = CNT_ZERO;
      end
`ifdef APPROX_MON_BIAS_EN
      bias_nxt_s = ACC_W'(sat_add_s({{(SAT_W-ACC_W){bias_o[ACC_W-1]}}, bias_o},
                                    {{(SAT_W-WIDTH-2){diff_s[WIDTH+1]}}, diff_s},
                                    ACC_W));
`endif
   end

   // Second stage: statistics accumulate, cleared by start_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sample_cnt_o <= CNT_ZERO;
         err_cnt_o    <= CNT_ZERO;
         sum_ed_o     <= {ACC_W{1'b0}};
         max_ed_o     <= {(WIDTH+1){1'b0}};
         sat_o        <= 1'b0;
`ifdef APPROX_MON_BIAS_EN
         bias_o       <= {ACC_W{1'b0}};
`endif
      end else if (start_i) begin
         sample_cnt_o <= CNT_ZERO;
         err_cnt_o    <= CNT_ZERO;
         sum_ed_o     <= {ACC_W{1'b0}};
         max_ed_o     <= {(WIDTH+1){1'b0}};
         sat_o        <= 1'b0;
`ifdef APPROX_MON_BIAS_EN
         bias_o       <= {ACC_W{1'b0}};
`endif
      end else if (s1_vld_s) begin
         sample_cnt_o <= sample_cnt_o + CNT_ONE;
         err_cnt_o    <= err_cnt_o + err_inc_s;
         sum_ed_o     <= sum_ed_nxt_s;
         max_ed_o     <= max_ed_nxt_s;
         sat_o        <= sat_o | sum_ovf_s;
`ifdef APPROX_MON_BIAS_EN
         bias_o       <= bias_nxt_s;
`endif
      end
   end

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed-vector bench for approx_adder_error_monitor, built with an 8-bit ED accumulator.
module tb_approx_adder_error_monitor;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 32;
   localparam int unsigned ACC_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] num_samples;
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] add1;
   logic [WIDTH-1:0] add2;
   logic [WIDTH:0]   approx;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [ACC_W-1:0] sum_ed;
   logic [WIDTH:0]   max_ed;
   logic             sat;
`ifdef APPROX_MON_BIAS_EN
   logic signed [ACC_W-1:0] bias;
`endif

   int n_vec     = 0;
   int n_miscmp  = 0;

   approx_adder_error_monitor #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .ACC_W (ACC_W)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .num_samples_i (num_samples),
      .valid_i       (valid),
      .ready_o       (ready),
      .add1_i        (add1),
      .add2_i        (add2),
      .approx_i      (approx),
      .busy_o        (busy),
      .done_o        (done),
      .sample_cnt_o  (sample_cnt),
      .err_cnt_o     (err_cnt),
      .sum_ed_o      (sum_ed),
      .max_ed_o      (max_ed),
      .sat_o         (sat)
`ifdef APPROX_MON_BIAS_EN
      ,
      .bias_o        (bias)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_win(input logic [CNT_W-1:0] n);
      start       = 1'b1;
      num_samples = n;
      tick();
      start       = 1'b0;
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH:0] ap);
      valid  = 1'b1;
      add1   = a;
      add2   = b;
      approx = ap;
      tick();
      valid  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 20 && !done; i++) tick();
      check_val(tag, 64'(done), 64'd1);
   endtask

   task automatic check_stats(input string tag, input logic [31:0] s, input logic [31:0] e,
                              input logic [7:0] sm, input logic [32:0] mx);
      check_val({tag, "_samples"}, 64'(sample_cnt), 64'(s));
      check_val({tag, "_errs"},    64'(err_cnt),    64'(e));
      check_val({tag, "_sum_ed"},  64'(sum_ed),     64'(sm));
      check_val({tag, "_max_ed"},  64'(max_ed),     64'(mx));
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [WIDTH:0] ex;
      logic           pat [6];
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      rst_n = 1'b0; start = 1'b0; num_samples = 32'd0; valid = 1'b0;
      add1 = 32'd0; add2 = 32'd0; approx = 33'd0;
      #12;
      check_val("rst_ready", 64'(ready), 64'd0);
      check_val("rst_busy",  64'(busy),  64'd0);
      check_val("rst_done",  64'(done),  64'd0);
      check_stats("rst", 32'd0, 32'd0, 8'd0, 33'd0);
      check_val("rst_sat",   64'(sat),   64'd0);
      rst_n = 1'b1;
      tick();

      // Exact match, one sample
      start_win(32'd1);
      check_val("t1_ready", 64'(ready), 64'd1);
      check_val("t1_busy",  64'(busy),  64'd1);
      send(32'h29AF2430, 32'h7A1B9ABC, 33'h0A3CABEEC);
      check_val("t1_ready_drop", 64'(ready), 64'd0);
      wait_done("t1_done");
      check_stats("t1", 32'd1, 32'd0, 8'h00, 33'h0);
`ifdef APPROX_MON_BIAS_EN
      check_val("t1_bias", 64'($signed(bias)), 64'd0);
`endif

      // Under and over estimate
      start_win(32'd2);
      check_val("t2_done_clr", 64'(done), 64'd0);
      send(32'h000000FF, 32'h00000001, 33'h0000000FF);
      send(32'h000000FF, 32'h00000001, 33'h000000110);
      wait_done("t2_done");
      check_stats("t2", 32'd2, 32'd2, 8'h11, 33'h10);
`ifdef APPROX_MON_BIAS_EN
      check_val("t2_bias", 64'($signed(bias)), 64'hFFFF_FFFF_FFFF_FFF1);
`endif

      // Gapped stream, 1-LSB over-estimates
      start_win(32'd4);
      for (int i = 0; i < 6; i++) begin
         valid  = pat[i];
         add1   = 32'h100 * i;
         add2   = 32'd3;
         ex     = {1'b0, add1} + {1'b0, add2};
         approx = ex + 33'd1;
         tick();
         if (i == 4) check_val("t3_ready_mid", 64'(ready), 64'd1);
      end
      valid = 1'b0;
      check_val("t3_ready_drop", 64'(ready), 64'd0);
      check_val("t3_done_early", 64'(done),  64'd0);
      tick();
      check_val("t3_done_early2", 64'(done), 64'd0);
      check_val("t3_samples_s2",  64'(sample_cnt), 64'd4);
      tick();
      check_val("t3_done_2cyc", 64'(done), 64'd1);
      check_val("t3_busy",      64'(busy), 64'd0);
      valid = 1'b1;
      tick();
      tick();
      valid = 1'b0;
      check_stats("t3", 32'd4, 32'd4, 8'd4, 33'd1);
`ifdef APPROX_MON_BIAS_EN
      check_val("t3_bias", 64'($signed(bias)), 64'hFFFF_FFFF_FFFF_FFFC);
`endif

      // Zero-length window
      start_win(32'd0);
      check_val("t4_done",  64'(done),  64'd1);
      check_val("t4_busy",  64'(busy),  64'd0);
      check_stats("t4", 32'd0, 32'd0, 8'd0, 33'd0);
      valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("t4_ready", 64'(ready), 64'd0);
      end
      valid = 1'b0;
      tick();
      check_val("t4_samples", 64'(sample_cnt), 64'd0);

      // Abort after 3 of 8, then a full window with ED = 0..7
      start_win(32'd8);
      for (int i = 0; i < 3; i++) send(32'd10, 32'd20, 33'd94);
      start_win(32'd8);
      check_stats("t5_clr", 32'd0, 32'd0, 8'd0, 33'd0);
      tick();
      check_val("t5_flush", 64'(sample_cnt), 64'd0);
      for (int i = 0; i < 8; i++) begin
         ex = {1'b0, 32'h100 * i} + 33'h10;
         send(32'h100 * i, 32'h10, ex - 33'(i));
      end
      check_val("t5_ready_drop", 64'(ready), 64'd0);
      wait_done("t5_done");
      check_stats("t5", 32'd8, 32'd7, 8'h1C, 33'd7);
`ifdef APPROX_MON_BIAS_EN
      check_val("t5_bias", 64'($signed(bias)), 64'd28);
`endif

      // Reset asserted while draining
      start_win(32'd2);
      send(32'd1, 32'd2, 33'd8);
      send(32'd1, 32'd2, 33'd8);
      check_val("t6_drain_busy", 64'(busy), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("t6_ready", 64'(ready), 64'd0);
      check_val("t6_busy",  64'(busy),  64'd0);
      check_val("t6_done",  64'(done),  64'd0);
      check_stats("t6", 32'd0, 32'd0, 8'd0, 33'd0);
      #3;
      rst_n = 1'b1;
      valid = 1'b1;
      tick();
      tick();
      valid = 1'b0;
      check_val("t6_idle_ready",   64'(ready),      64'd0);
      check_val("t6_idle_samples", 64'(sample_cnt), 64'd0);

      // Saturating ED sum
      start_win(32'd3);
      for (int i = 0; i < 3; i++) send(32'd0, 32'd0, 33'h80);
      wait_done("t7_done");
      check_stats("t7", 32'd3, 32'd3, 8'hFF, 33'h80);
      check_val("t7_sat", 64'(sat), 64'd1);
`ifdef APPROX_MON_BIAS_EN
      check_val("t7_bias", 64'($signed(bias)), 64'hFFFF_FFFF_FFFF_FF80);
`endif
      start_win(32'd1);
      check_val("t7_sat_clr", 64'(sat), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule

// File: doc/approx_adder_error_monitor.md
Name: approx_adder_error_monitor

Overview:
- Sequential checker that sits at the output end of any approximate adder in the adders32 family.
- Accepts streamed operand pairs together with the DUT's approximate sum and computes the exact sum internally.
- Over a programmable sample window it accumulates error statistics: error count, sum of error distance (ED) and maximum ED.
- Used in post-synthesis and FPGA runs so that accuracy is measured in hardware instead of by eye from a monitor log.

Parameters:
- WIDTH, 32, operand width; the approximate result is WIDTH+1 bits.
- CNT_W, 32, width of the sample and error counters.
- ACC_W, 48, width of the ED accumulator.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle pulse; arms a new window and clears all statistics.
- num_samples_i  input  CNT_W  window length, sampled on start_i.
- valid_i  input  1  sample valid.
- ready_o  output  1  sample accepted when valid_i && ready_o.
- add1_i  input  WIDTH  operand A.
- add2_i  input  WIDTH  operand B.
- approx_i  input  WIDTH+1  DUT result for add1_i/add2_i.
- busy_o  output  1  window active or pipeline draining.
- done_o  output  1  statistics final.
- sample_cnt_o  output  CNT_W  samples accumulated so far.
- err_cnt_o  output  CNT_W  samples with ED != 0.
- sum_ed_o  output  ACC_W  saturating sum of ED.
- max_ed_o  output  WIDTH+1  largest ED seen.
- sat_o  output  1  sticky; sum_ed_o has saturated.

Behaviour:
- Reset: state IDLE; ready_o, busy_o and done_o are 0; all counters, sum_ed_o, max_ed_o and sat_o are 0.
- FSM IDLE -> RUN on start_i:
  - Latch num_samples_i into a limit register; clear all statistics, sat_o and the accepted count.
  - If num_samples_i == 0, go directly to DONE on the next cycle with all statistics zero.
- RUN:
  - ready_o = 1 and busy_o = 1.
  - Each handshake increments an internal accepted count.
  - The handshake that makes accepted count equal to the limit moves the FSM to DRAIN on the next edge; ready_o drops in that same next cycle.
- DRAIN: ready_o = 0, busy_o = 1; wait until the pipeline is empty, then go to DONE.
- DONE: done_o = 1, busy_o = 0, outputs held; start_i re-arms the monitor (DONE -> RUN, same clearing rules as from IDLE).
- start_i in RUN or DRAIN: abort the current window, discard in-flight samples, restart (RUN with cleared statistics).
- Pipeline, 2 stages:
  - S1 registers exact = add1_i + add2_i (WIDTH+1 bits, zero-extended) and ed = |exact - approx_i|, computed as an unsigned magnitude.
  - S2 updates the statistics: sample_cnt +1; err_cnt +1 if ed != 0; sum_ed += ed; max_ed = max(max_ed, ed).
  - Statistic outputs reflect a sample 2 cycles after its handshake.
- sum_ed saturation: if the addition overflows ACC_W, sum_ed holds all-ones and sat_o is set; sat_o stays set until start_i.
- The counters do not wrap: the window limit is at most 2^CNT_W - 1.
- valid_i is ignored while ready_o = 0. No back-pressure toward the DUT is required beyond ready_o.
- Asynchronous reset mid-window returns every register to its reset value immediately.

Optional Feature:
- Macro: APPROX_MON_BIAS_EN.
- When defined:
  - Adds output bias_o, signed, ACC_W bits: saturating sum of (exact - approx_i) as a signed WIDTH+2-bit value.
  - Cleared on start_i and updated in S2.
  - Reveals systematic under/over-estimation, e.g. lower-part-OR adders under-estimate.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package approx_mon_pkg:
  - FSM state enum: IDLE, RUN, DRAIN, DONE.
  - Default widths.
  - Saturating-add function.
- One sub-module: approx_ed_stage (S1: exact sum plus absolute difference, registered). The FSM and accumulators stay in the top module.

Test Plan:
- Exact match: num_samples = 1, add1 = 0x29AF2430, add2 = 0x7A1B9ABC, approx = 0x0A3CABEEC -> done_o = 1; sample_cnt = 1, err_cnt = 0, sum_ed = 0, max_ed = 0.
- Under/over estimate: num_samples = 2:
  - Sample 1: add1 = 0x000000FF, add2 = 0x00000001, approx = 0x0000000FF (ED = 1).
  - Sample 2: same operands, approx = 0x000000110 (ED = 0x10).
  - Expected: err_cnt = 2, sum_ed = 0x11, max_ed = 0x10. With APPROX_MON_BIAS_EN: bias = 1 - 16 = -15.
- Back-to-back and gaps: num_samples = 4 with valid_i toggling 1,0,1,1,0,1 and 1-LSB errors -> exactly 4 accepted; ready_o drops the cycle after the 4th handshake; done_o rises 2 cycles after the last handshake; sum_ed = 4.
- Zero window: start_i with num_samples = 0 -> done_o the next cycle; ready_o never asserts; all statistics zero.
- Abort and reset:
  - start_i pulsed mid-window after 3 of 8 samples -> statistics clear and the new 8-sample window completes.
  - rst_ni low during DRAIN -> all outputs 0 immediately, state IDLE.
- Saturation: ACC_W = 8, num_samples = 3, each ED = 0x80 -> sum_ed = 0xFF, sat_o = 1, max_ed = 0x80.
